// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: register-file write-back request bundle shared by three requesters and the arbiter
interface wb_arbiter_if #(parameter int XLEN = 32);
  logic            iStall;
  logic            iMemValid, oMemReady;
  logic [4:0]      iMemRd;
  logic [XLEN-1:0] iMemData;
  logic            iBrValid, oBrReady;
  logic [4:0]      iBrRd;
  logic [XLEN-1:0] iBrData;
  logic            iAluValid, oAluReady;
  logic [4:0]      iAluRd;
  logic [XLEN-1:0] iAluData;
  logic            oRdWe;
  logic [4:0]      oRdAddr;
  logic [XLEN-1:0] oRdData;
  logic [15:0]     oConflictCnt;
  modport slave (
    input  iStall, iMemValid, iMemRd, iMemData, iBrValid, iBrRd, iBrData, iAluValid, iAluRd, iAluData,
    output oMemReady, oBrReady, oAluReady, oRdWe, oRdAddr, oRdData, oConflictCnt
  );
  modport master (
    output iStall, iMemValid, iMemRd, iMemData, iBrValid, iBrRd, iBrData, iAluValid, iAluRd, iAluData,
    input  oMemReady, oBrReady, oAluReady, oRdWe, oRdAddr, oRdData, oConflictCnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: fixed-priority (mem > br > alu) write-back arbiter with age promotion against starvation
module wb_arbiter #(
  parameter int XLEN      = 32,
  parameter int AGE_LIMIT = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  wb_arbiter_if.slave   bus
);
  localparam logic [3:0] LIM = 4'(AGE_LIMIT);
  logic [2:0]      w_v, w_p, w_sel, w_g;
  logic            w_multi;
  logic [4:0]      w_rd [3];
  logic [XLEN-1:0] w_data [3];
  logic [4:0]      w_grd;
  logic [XLEN-1:0] w_gdata;
  logic [3:0]      r_age [3];
  logic [15:0]     r_cnt;
  logic            r_we;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_data;
  assign w_v = {bus.iAluValid, bus.iBrValid, bus.iMemValid};
  always_comb begin
    w_rd[0]   = bus.iMemRd;
    w_rd[1]   = bus.iBrRd;
    w_rd[2]   = bus.iAluRd;
    w_data[0] = bus.iMemData;
    w_data[1] = bus.iBrData;
    w_data[2] = bus.iAluData;
  end
  for (genvar i = 0; i < 3; i++) begin : g_p
    assign w_p[i] = w_v[i] && r_age[i] == LIM;
  end
  // promoted requesters form the candidate set when any exist; lowest set bit wins
  assign w_sel   = |w_p ? w_p : w_v;
  assign w_g     = (iRst && !bus.iStall) ? (w_sel & (~w_sel + 3'd1)) : 3'd0;
  assign w_multi = (w_v[0] & w_v[1]) | (w_v[0] & w_v[2]) | (w_v[1] & w_v[2]);
  assign w_grd   = w_g[0] ? w_rd[0] : w_g[1] ? w_rd[1] : w_rd[2];
  assign w_gdata = w_g[0] ? w_data[0] : w_g[1] ? w_data[1] : w_data[2];
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int i = 0; i < 3; i++) r_age[i] <= 4'd0;
      r_cnt  <= 16'd0;
      r_we   <= 1'b0;
      r_addr <= 5'd0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (!bus.iStall) r_age[i] <= (!w_v[i] || w_g[i]) ? 4'd0 : (r_age[i] >= LIM ? LIM : r_age[i] + 4'd1);
      r_cnt <= (!bus.iStall && w_multi && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
      r_we  <= |w_g && w_grd != 5'd0;
      if (|w_g) begin
        r_addr <= w_grd;
        r_data <= w_gdata;
      end
    end
  end
  assign bus.oMemReady    = w_g[0];
  assign bus.oBrReady     = w_g[1];
  assign bus.oAluReady    = w_g[2];
  assign bus.oRdWe        = r_we;
  assign bus.oRdAddr      = r_addr;
  assign bus.oRdData      = r_data;
  assign bus.oConflictCnt = r_cnt;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios with a write-back scoreboard for wb_arbiter
module tb_wb_arbiter;
  typedef struct packed {logic we; logic [4:0] a; logic [31:0] d;} wb_t;
  logic iClk = 1'b0;
  logic iRst = 1'b0;
  int checks = 0;
  int errors = 0;
  string phase = "init";
  wb_t sb[$];
  wb_arbiter_if #(.XLEN(32)) bus ();
  wb_arbiter #(.XLEN(32), .AGE_LIMIT(4)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
  always #5 iClk = ~iClk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, act, exp);
    end
  endtask
  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d);
    sb.push_back({we, a, d});
  endtask
  task automatic tick;
    wb_t e;
    @(posedge iClk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("we", bus.oRdWe, e.we);
      chk("addr", bus.oRdAddr, e.a);
      chk("data", bus.oRdData, e.d);
    end
  endtask
  task automatic rdy(input logic m, input logic b, input logic a);
    #1;
    chk("rdy", {bus.oMemReady, bus.oBrReady, bus.oAluReady}, {m, b, a});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.iStall = 0;
    bus.iMemValid = 1; bus.iMemRd = 5'd3; bus.iMemData = 32'h55;
    bus.iBrValid = 0;  bus.iBrRd = 0;  bus.iBrData = 0;
    bus.iAluValid = 0; bus.iAluRd = 0; bus.iAluData = 0;
    phase = "reset";
    #12;
    chk("rst_out", {bus.oRdWe, bus.oRdAddr, bus.oRdData, bus.oConflictCnt}, 0);
    chk("rst_rdy", bus.oMemReady, 0);
    bus.iMemValid = 0;
    #1 iRst = 1;
    phase = "single";
    bus.iAluValid = 1; bus.iAluRd = 5'd5; bus.iAluData = 32'hDEAD_BEEF;
    rdy(0, 0, 1);
    push(1, 5, 32'hDEAD_BEEF); tick;
    bus.iAluValid = 0;
    rdy(0, 0, 0);
    push(0, 5, 32'hDEAD_BEEF); tick;
    phase = "contend";
    bus.iMemValid = 1; bus.iMemRd = 1; bus.iMemData = 32'hA;
    bus.iBrValid = 1;  bus.iBrRd = 2;  bus.iBrData = 32'hB;
    bus.iAluValid = 1; bus.iAluRd = 3; bus.iAluData = 32'hC;
    rdy(1, 0, 0); push(1, 1, 32'hA); tick; bus.iMemValid = 0;
    rdy(0, 1, 0); push(1, 2, 32'hB); tick; bus.iBrValid = 0;
    rdy(0, 0, 1); push(1, 3, 32'hC); tick; bus.iAluValid = 0;
    push(0, 3, 32'hC); tick;
    chk("conflict", bus.oConflictCnt, 2);
    phase = "x0";
    bus.iBrValid = 1; bus.iBrRd = 0; bus.iBrData = 32'h1234;
    rdy(0, 1, 0); push(0, 0, 32'h1234); tick; bus.iBrValid = 0;
    push(0, 0, 32'h1234); tick;
    phase = "stall";
    bus.iStall = 1; bus.iMemValid = 1; bus.iMemRd = 7; bus.iMemData = 32'h77;
    for (int k = 0; k < 3; k++) begin
      rdy(0, 0, 0); push(0, 0, 32'h1234); tick;
    end
    bus.iStall = 0;
    rdy(1, 0, 0); push(1, 7, 32'h77); tick; bus.iMemValid = 0;
    push(0, 7, 32'h77); tick;
    chk("conflict", bus.oConflictCnt, 2);
    phase = "starve";
    bus.iAluValid = 1; bus.iAluRd = 20; bus.iAluData = 32'hA1;
    bus.iMemValid = 1;
    for (int k = 0; k < 4; k++) begin
      bus.iMemRd = 5'(10 + k); bus.iMemData = 32'(k);
      rdy(1, 0, 0); push(1, 5'(10 + k), 32'(k)); tick;
    end
    bus.iMemRd = 14; bus.iMemData = 32'h4;
    rdy(0, 0, 1); push(1, 20, 32'hA1); tick; bus.iAluValid = 0;
    rdy(1, 0, 0); push(1, 14, 32'h4); tick; bus.iMemValid = 0;
    push(0, 14, 32'h4); tick;
    chk("conflict", bus.oConflictCnt, 7);
    phase = "areset";
    bus.iMemValid = 1; bus.iMemRd = 9; bus.iMemData = 32'h99;
    push(1, 9, 32'h99); tick;
    #2 iRst = 0;
    rdy(0, 0, 0);
    chk("rst_out", {bus.oRdWe, bus.oRdAddr, bus.oRdData, bus.oConflictCnt}, 0);
    @(posedge iClk); #2;
    bus.iMemValid = 0;
    iRst = 1;
    push(0, 0, 32'h0); tick;
    bus.iAluValid = 1; bus.iAluRd = 4; bus.iAluData = 32'h44;
    rdy(0, 0, 1); push(1, 4, 32'h44); tick; bus.iAluValid = 0;
    push(0, 4, 32'h44); tick;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
